// File: rtl/rv32i_decode_issue_if.sv
// Bundle of the upstream instruction handshake, register-file read port,
// flush control and the downstream ALU issue fields of the decode stage.
`timescale 1ns/1ps
interface rv32i_decode_issue_if #(
  parameter int COUNT_WIDTH = 32
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_insn;
  logic [31:0]            in_pc;
  logic [4:0]             rf_rs1_addr;
  logic [4:0]             rf_rs2_addr;
  logic [31:0]            rf_rs1_data;
  logic [31:0]            rf_rs2_data;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            op1;
  logic [31:0]            op2;
  logic [2:0]             funct3;
  logic [6:0]             funct7;
  logic [4:0]             shamt;
  logic [2:0]             insn_type;
  logic [4:0]             out_rd;
  logic [31:0]            out_rs1_val;
  logic [31:0]            out_rs2_val;
  logic [31:0]            out_pc;
  logic                   out_illegal;
  logic [COUNT_WIDTH-1:0] issue_count;

  // Decode stage side.
  modport slave (
    input  in_valid, in_insn, in_pc, rf_rs1_data, rf_rs2_data, flush, out_ready,
    output in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, op1, op2, funct3,
           funct7, shamt, insn_type, out_rd, out_rs1_val, out_rs2_val, out_pc,
           out_illegal, issue_count
  );

  // Fetch / register file / execute side.
  modport master (
    output in_valid, in_insn, in_pc, rf_rs1_data, rf_rs2_data, flush, out_ready,
    input  in_ready, rf_rs1_addr, rf_rs2_addr, out_valid, op1, op2, funct3,
           funct7, shamt, insn_type, out_rd, out_rs1_val, out_rs2_val, out_pc,
           out_illegal, issue_count
  );
endinterface

// File: rtl/rv32i_decode_issue.sv
// RV32I decode/issue stage: decodes one instruction per cycle into ALU
// operands and control fields, holds it in a single output register, and
// stalls one cycle when an instruction needs the result of the load ahead.
`timescale 1ns/1ps
module rv32i_decode_issue #(
  parameter bit LOAD_USE_INTERLOCK = 1'b1,
  parameter int COUNT_WIDTH        = 32
) (
  input  logic               clk,
  input  logic               rst,
  rv32i_decode_issue_if.slave bus
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Instruction fields
  logic [31:0] insn;
  logic [6:0]  opcode;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign insn    = bus.in_insn;
  assign opcode  = insn[6:0];
  assign rd_idx  = insn[11:7];
  assign rs1_idx = insn[19:15];
  assign rs2_idx = insn[24:20];
  assign imm_i   = {{20{insn[31]}}, insn[31:20]};
  assign imm_s   = {{20{insn[31]}}, insn[31:25], insn[11:7]};
  assign imm_b   = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
  assign imm_u   = {insn[31:12], 12'b0};
  assign imm_j   = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

  // x0 is hardwired to zero whatever the register file returns.
  assign rs1_val = (rs1_idx == 5'd0) ? 32'd0 : bus.rf_rs1_data;
  assign rs2_val = (rs2_idx == 5'd0) ? 32'd0 : bus.rf_rs2_data;

  assign bus.rf_rs1_addr = rs1_idx;
  assign bus.rf_rs2_addr = rs2_idx;

  // Decoded next values
  logic [31:0] op1_next;
  logic [31:0] op2_next;
  logic [2:0]  funct3_next;
  logic [6:0]  funct7_next;
  logic [4:0]  shamt_next;
  logic [2:0]  type_next;
  logic [4:0]  rd_next;
  logic        illegal_next;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        is_load;

  // Registered state
  logic                   out_valid_reg;
  logic [31:0]            op1_reg;
  logic [31:0]            op2_reg;
  logic [2:0]             funct3_reg;
  logic [6:0]             funct7_reg;
  logic [4:0]             shamt_reg;
  logic [2:0]             type_reg;
  logic [4:0]             rd_reg;
  logic [31:0]            rs1_val_reg;
  logic [31:0]            rs2_val_reg;
  logic [31:0]            pc_reg;
  logic                   illegal_reg;
  logic [COUNT_WIDTH-1:0] issue_count_reg;
  logic                   ld_pending_reg;
  logic [4:0]             ld_rd_reg;

  logic hazard;
  logic in_ready;
  logic accept;
  logic xfer;

  // Opcode decode into ALU operands, control fields and hazard-relevant uses.
  always_comb begin
    op1_next     = 32'd0;
    op2_next     = 32'd0;
    funct3_next  = insn[14:12];
    funct7_next  = 7'd0;
    shamt_next   = 5'd0;
    type_next    = 3'b111;
    rd_next      = rd_idx;
    illegal_next = 1'b0;
    uses_rs1     = 1'b1;
    uses_rs2     = 1'b0;
    is_load      = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        type_next   = 3'b000;
        op1_next    = rs1_val;
        op2_next    = imm_i;
        shamt_next  = insn[24:20];
        funct7_next = insn[31:25];
      end
      OPC_OP: begin
        type_next   = 3'b001;
        op1_next    = rs1_val;
        op2_next    = rs2_val;
        funct7_next = insn[31:25];
        uses_rs2    = 1'b1;
      end
      OPC_STORE: begin
        type_next = 3'b010;
        op1_next  = rs1_val;
        op2_next  = imm_s;
        rd_next   = 5'd0;
        uses_rs2  = 1'b1;
      end
      OPC_LOAD: begin
        type_next = 3'b011;
        op1_next  = rs1_val;
        op2_next  = imm_i;
        is_load   = 1'b1;
      end
      OPC_JAL: begin
        type_next = 3'b101;
        op1_next  = bus.in_pc;
        op2_next  = imm_j;
        uses_rs1  = 1'b0;
      end
      OPC_JALR: begin
        type_next = 3'b101;
        op1_next  = rs1_val;
        op2_next  = imm_i;
      end
      OPC_BRANCH: begin
        type_next = 3'b110;
        op1_next  = bus.in_pc;
        op2_next  = imm_b;
        rd_next   = 5'd0;
        uses_rs2  = 1'b1;
      end
      OPC_LUI: begin
        type_next   = 3'b000;
        funct3_next = 3'b000;
        op1_next    = 32'd0;
        op2_next    = imm_u;
        uses_rs1    = 1'b0;
      end
      OPC_AUIPC: begin
        type_next   = 3'b000;
        funct3_next = 3'b000;
        op1_next    = bus.in_pc;
        op2_next    = imm_u;
        uses_rs1    = 1'b0;
      end
      default: begin
        illegal_next = 1'b1;
        rd_next      = 5'd0;
      end
    endcase
  end

  // The interlock can be compiled out; without it the hazard term is tied low.
  generate
    if (LOAD_USE_INTERLOCK) begin : g_interlock
      assign hazard = ld_pending_reg &&
                      ((uses_rs1 && (rs1_idx == ld_rd_reg)) ||
                       (uses_rs2 && (rs2_idx == ld_rd_reg)));
    end else begin : g_no_interlock
      assign hazard = 1'b0;
    end
  endgenerate

  assign in_ready = !rst && !(out_valid_reg && !bus.out_ready) && !hazard && !bus.flush;
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = out_valid_reg && bus.out_ready;

  // Output valid: set on accept, cleared on hand-off; flush kills the held entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
    end else if (xfer) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Output data fields load only on accept so they stay stable during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_reg     <= 32'd0;
      op2_reg     <= 32'd0;
      funct3_reg  <= 3'd0;
      funct7_reg  <= 7'd0;
      shamt_reg   <= 5'd0;
      type_reg    <= 3'd0;
      rd_reg      <= 5'd0;
      rs1_val_reg <= 32'd0;
      rs2_val_reg <= 32'd0;
      pc_reg      <= 32'd0;
      illegal_reg <= 1'b0;
    end else if (accept) begin
      op1_reg     <= op1_next;
      op2_reg     <= op2_next;
      funct3_reg  <= funct3_next;
      funct7_reg  <= funct7_next;
      shamt_reg   <= shamt_next;
      type_reg    <= type_next;
      rd_reg      <= rd_next;
      rs1_val_reg <= rs1_val;
      rs2_val_reg <= rs2_val;
      pc_reg      <= bus.in_pc;
      illegal_reg <= illegal_next;
    end
  end

  // Load tracking: a newly accepted load wins over the hand-off clearing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_pending_reg <= 1'b0;
      ld_rd_reg      <= 5'd0;
    end else if (bus.flush) begin
      ld_pending_reg <= 1'b0;
    end else if (accept && is_load && (rd_idx != 5'd0)) begin
      ld_pending_reg <= 1'b1;
      ld_rd_reg      <= rd_idx;
    end else if (xfer) begin
      ld_pending_reg <= 1'b0;
    end
  end

  // Count legal instructions that actually leave the stage; a flushed one does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count_reg <= '0;
    end else if (xfer && !bus.flush && !illegal_reg) begin
      issue_count_reg <= issue_count_reg + 1'b1;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_reg;
  assign bus.op1         = op1_reg;
  assign bus.op2         = op2_reg;
  assign bus.funct3      = funct3_reg;
  assign bus.funct7      = funct7_reg;
  assign bus.shamt       = shamt_reg;
  assign bus.insn_type   = type_reg;
  assign bus.out_rd      = rd_reg;
  assign bus.out_rs1_val = rs1_val_reg;
  assign bus.out_rs2_val = rs2_val_reg;
  assign bus.out_pc      = pc_reg;
  assign bus.out_illegal = illegal_reg;
  assign bus.issue_count = issue_count_reg;

endmodule

// File: tb/tb_rv32i_decode_issue.sv
// Bench for the decode/issue stage: expected fields are queued as each
// instruction is accepted and compared when the stage hands it downstream.
`timescale 1ns/1ps
module tb_rv32i_decode_issue;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rv32i_decode_issue_if #(.COUNT_WIDTH(32)) bus ();

  rv32i_decode_issue #(.LOAD_USE_INTERLOCK(1'b1), .COUNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file model: xN holds N*10; x0 returns junk the stage must ignore.
  always_comb begin
    bus.rf_rs1_data = (bus.rf_rs1_addr == 5'd0) ? 32'hDEADBEEF : {27'd0, bus.rf_rs1_addr} * 32'd10;
    bus.rf_rs2_data = (bus.rf_rs2_addr == 5'd0) ? 32'hDEADBEEF : {27'd0, bus.rf_rs2_addr} * 32'd10;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  itype;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        ill;
    logic        chk_shamt;
    logic [4:0]  shamt;
    logic        chk_rs;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_cnt = 32'd0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic        rec_en = 1'b0;
  logic        rec[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2,
                              input logic [2:0] itype, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd, input logic ill);
    exp_t e;
    e.pc = pc; e.op1 = op1; e.op2 = op2; e.itype = itype; e.f3 = f3; e.f7 = f7;
    e.rd = rd; e.ill = ill; e.chk_shamt = 1'b0; e.shamt = 5'd0;
    e.chk_rs = 1'b0; e.rs1v = 32'd0; e.rs2v = 32'd0;
    return e;
  endfunction

  // Present one instruction and wait (bounded) for the stage to take it.
  task automatic send(input logic [31:0] insn, input logic [31:0] pc, input exp_t e);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_insn  = insn;
    bus.in_pc    = pc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        q.push_back(e);
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait until every queued instruction has been handed off.
  task automatic drain();
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    check("drain_empty", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each hand-off against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rec_en) rec.push_back(bus.out_valid);
    if (!rst) begin
      check("issue_count", bus.issue_count, exp_cnt);
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
        if (q.size() == 0) begin
          check("unexpected_output", 32'(bus.out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          $display("xfer pc=%08h type=%0d op1=%08h op2=%08h f3=%0d f7=%02h rd=%0d ill=%0b",
                   bus.out_pc, bus.insn_type, bus.op1, bus.op2, bus.funct3, bus.funct7,
                   bus.out_rd, bus.out_illegal);
          check("out_pc", bus.out_pc, e.pc);
          check("op1", bus.op1, e.op1);
          check("op2", bus.op2, e.op2);
          check("insn_type", 32'(bus.insn_type), 32'(e.itype));
          check("funct3", 32'(bus.funct3), 32'(e.f3));
          check("funct7", 32'(bus.funct7), 32'(e.f7));
          check("out_rd", 32'(bus.out_rd), 32'(e.rd));
          check("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
          if (e.chk_shamt) check("shamt", 32'(bus.shamt), 32'(e.shamt));
          if (e.chk_rs) begin
            check("out_rs1_val", bus.out_rs1_val, e.rs1v);
            check("out_rs2_val", bus.out_rs2_val, e.rs2v);
          end
          if (!e.ill) exp_cnt = exp_cnt + 32'd1;
        end
      end
    end
  end

  // Find the first valid sample in the recorded trace.
  function automatic int first_one();
    for (int i = 0; i < rec.size(); i++) if (rec[i]) return i;
    return 0;
  endfunction

  initial begin
    exp_t        e;
    logic [31:0] cnt_before;
    int          idx;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_insn   = 32'd0;
    bus.in_pc     = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_issue_count", bus.issue_count, 32'd0);
    check("rst_op1", bus.op1, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADDI x5,x1,-3
    e = mk(32'h0, 32'd10, 32'hFFFFFFFD, 3'b000, 3'b000, 7'h7F, 5'd5, 1'b0);
    e.chk_shamt = 1'b1; e.shamt = 5'd29;
    send(32'hFFD08293, 32'h0, e);
    drain();
    check("issue_count_after_addi", bus.issue_count, 32'd1);

    // SRAI x3,x2,4
    e = mk(32'h4, 32'd20, 32'h00000404, 3'b000, 3'b101, 7'b0100000, 5'd3, 1'b0);
    e.chk_shamt = 1'b1; e.shamt = 5'd4;
    send(32'h40415193, 32'h4, e);
    // SUB x3,x1,x2
    e = mk(32'h8, 32'd10, 32'd20, 3'b001, 3'b000, 7'b0100000, 5'd3, 1'b0);
    e.chk_rs = 1'b1; e.rs1v = 32'd10; e.rs2v = 32'd20;
    send(32'h402081B3, 32'h8, e);
    // BEQ x1,x2,-8 at 0x100
    e = mk(32'h100, 32'h100, 32'hFFFFFFF8, 3'b110, 3'b000, 7'd0, 5'd0, 1'b0);
    e.chk_rs = 1'b1; e.rs1v = 32'd10; e.rs2v = 32'd20;
    send(32'hFE208CE3, 32'h100, e);
    // LUI x7,0x12345
    send(32'h123453B7, 32'h104, mk(32'h104, 32'd0, 32'h12345000, 3'b000, 3'b000, 7'd0, 5'd7, 1'b0));
    // AUIPC x8,0x1 at 0x200
    send(32'h00001417, 32'h200, mk(32'h200, 32'h200, 32'h00001000, 3'b000, 3'b000, 7'd0, 5'd8, 1'b0));
    // SW x2,12(x1)
    e = mk(32'h204, 32'd10, 32'd12, 3'b010, 3'b010, 7'd0, 5'd0, 1'b0);
    e.chk_rs = 1'b1; e.rs1v = 32'd10; e.rs2v = 32'd20;
    send(32'h0020A623, 32'h204, e);
    // JAL x1,16 at 0x300
    send(32'h010000EF, 32'h300, mk(32'h300, 32'h300, 32'd16, 3'b101, 3'b000, 7'd0, 5'd1, 1'b0));
    // JALR x1,4(x5)
    send(32'h004280E7, 32'h304, mk(32'h304, 32'd50, 32'd4, 3'b101, 3'b000, 7'd0, 5'd1, 1'b0));
    // ADDI x5,x0,7: x0 must read as zero
    e = mk(32'h308, 32'd0, 32'd7, 3'b000, 3'b000, 7'd0, 5'd5, 1'b0);
    e.chk_shamt = 1'b1; e.shamt = 5'd7;
    e.chk_rs = 1'b1; e.rs1v = 32'd0; e.rs2v = 32'd70;
    send(32'h00700293, 32'h308, e);
    drain();

    // LW x4,0(x1) then dependent ADD x6,x4,x2: one bubble
    rec.delete();
    rec_en = 1'b1;
    send(32'h0000A203, 32'h400, mk(32'h400, 32'd10, 32'd0, 3'b011, 3'b010, 7'd0, 5'd4, 1'b0));
    send(32'h00220333, 32'h404, mk(32'h404, 32'd40, 32'd20, 3'b001, 3'b000, 7'd0, 5'd6, 1'b0));
    drain();
    repeat (2) @(negedge clk);
    rec_en = 1'b0;
    idx = first_one();
    check("bubble_lw_valid", 32'(rec[idx]), 32'd1);
    check("bubble_gap", 32'(rec[idx+1]), 32'd0);
    check("bubble_add_valid", 32'(rec[idx+2]), 32'd1);

    // LW x4 then independent ADD x6,x9,x2: back to back
    @(posedge clk);
    #1;
    rec.delete();
    rec_en = 1'b1;
    send(32'h0000A203, 32'h410, mk(32'h410, 32'd10, 32'd0, 3'b011, 3'b010, 7'd0, 5'd4, 1'b0));
    send(32'h00248333, 32'h414, mk(32'h414, 32'd90, 32'd20, 3'b001, 3'b000, 7'd0, 5'd6, 1'b0));
    drain();
    rec_en = 1'b0;
    idx = first_one();
    check("nobubble_lw_valid", 32'(rec[idx]), 32'd1);
    check("nobubble_add_valid", 32'(rec[idx+1]), 32'd1);

    // Stall: output held for 3 cycles while the next instruction waits
    bus.out_ready = 1'b0;
    e = mk(32'h500, 32'd10, 32'd20, 3'b001, 3'b000, 7'b0100000, 5'd3, 1'b0);
    send(32'h402081B3, 32'h500, e);
    cnt_before = exp_cnt;
    bus.in_valid = 1'b1;
    bus.in_insn  = 32'h00700293;
    bus.in_pc    = 32'h504;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_op1", bus.op1, 32'd10);
      check("stall_op2", bus.op2, 32'd20);
      check("stall_funct7", 32'(bus.funct7), 32'h20);
      check("stall_pc", bus.out_pc, 32'h500);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    check("stall_issue_count", bus.issue_count, cnt_before + 32'd1);

    // Flush while an instruction is held and execute is ready
    bus.out_ready = 1'b0;
    send(32'hFFD08293, 32'h600, mk(32'h600, 32'd10, 32'hFFFFFFFD, 3'b000, 3'b000, 7'h7F, 5'd5, 1'b0));
    cnt_before    = exp_cnt;
    void'(q.pop_back());
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_insn   = 32'h00700293;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_issue_count", bus.issue_count, cnt_before);

    // Illegal opcode: handed off but not counted
    @(posedge clk);
    #1;
    cnt_before = exp_cnt;
    send(32'h0000007F, 32'h700, mk(32'h700, 32'd0, 32'd0, 3'b111, 3'b000, 7'd0, 5'd0, 1'b1));
    drain();
    check("illegal_issue_count", bus.issue_count, cnt_before);

    // Async reset in the middle of a stall with a load pending
    bus.out_ready = 1'b0;
    send(32'h0000A203, 32'h800, mk(32'h800, 32'd10, 32'd0, 3'b011, 3'b010, 7'd0, 5'd4, 1'b0));
    @(negedge clk);
    check("pre_rst_ld_pending", 32'(dut.ld_pending_reg), 32'd1);
    #2;
    rst = 1'b1;
    q.delete();
    exp_cnt = 32'd0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_issue_count", bus.issue_count, 32'd0);
    check("async_rst_op1", bus.op1, 32'd0);
    check("async_rst_out_rd", 32'(bus.out_rd), 32'd0);
    check("async_rst_ld_pending", 32'(dut.ld_pending_reg), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Recovery after reset: dependent ADD on x4 issues with no stale interlock
    rec.delete();
    rec_en = 1'b1;
    send(32'h00220333, 32'h900, mk(32'h900, 32'd40, 32'd20, 3'b001, 3'b000, 7'd0, 5'd6, 1'b0));
    drain();
    rec_en = 1'b0;
    check("post_rst_issue_count", bus.issue_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
